reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 8x16 general-purpose register file.
- Provides two read ports with registered, 1-cycle read latency, one write port, and write-to-read bypass.
- Adds a per-register busy scoreboard (lock on issue, clear on writeback), so the control unit can detect RAW hazards instead of relying on the single Reg_load mode bit.
- Sits between the decoder (addresses, lock requests) and the ALU/writeback path; exposes two debug taps for the top-level observation outputs.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; power of two, 2..32.
- AW, $clog2(DEPTH), address width (derived; do not override).
- RESET_VALS, packed DEPTH*WIDTH vector, default {5000,500,0,10000,1,100,1000,10} (entry i at bits [i*WIDTH +: WIDTH]), per-register reset contents.
- ZERO_REG, 0, if 1 register 0 always reads 0 and ignores writes and locks.
- DBG_ADDR0, 0, register mirrored on dbg_data0.
- DBG_ADDR1, 2, register mirrored on dbg_data1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request for both ports this cycle.
- rd_addr_a  in  AW  port A read address.
- rd_addr_b  in  AW  port B read address.
- rd_data_a  out  WIDTH  registered port A data.
- rd_data_b  out  WIDTH  registered port B data.
- rd_valid  out  1  registered; data is hazard-free.
- busy_a  out  1  combinational; rd_addr_a is locked and not being written this cycle.
- busy_b  out  1  same for rd_addr_b.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- lock_en  in  1  reserve lock_addr as pending destination.
- lock_addr  in  AW  register to reserve.
- dbg_data0  out  WIDTH  combinational copy of mem[DBG_ADDR0].
- dbg_data1  out  WIDTH  combinational copy of mem[DBG_ADDR1].

Behaviour:
- Reset (async assert, sync release):
  - mem[i] = RESET_VALS entry i.
  - All busy bits cleared.
  - rd_data_a = rd_data_b = 0; rd_valid = 0.
  - A read in flight at reset is discarded; no output reflects it after reset.
- Write: at posedge with wr_en=1, mem[wr_addr] <= wr_data. Ignored for addr 0 when ZERO_REG=1.
- Read:
  - At posedge with rd_en=1, rd_data_x <= effective value of mem[rd_addr_x].
  - rd_valid <= ~(busy_a | busy_b).
  - With rd_en=0, rd_data_a/rd_data_b hold their values and rd_valid <= 0.
- Latency: address in cycle N gives data and rd_valid in cycle N+1.
- Bypass (write-first): if wr_en and wr_addr equals rd_addr_x in the same cycle, rd_data_x <= wr_data, not the old contents. Applies to A and B independently; both ports may hit the same address.
- ZERO_REG=1, address 0: read returns 0 regardless of bypass; busy for address 0 is always 0.
- Scoreboard:
  - busy[i] is set at posedge when lock_en and lock_addr==i.
  - busy[i] is cleared at posedge when wr_en and wr_addr==i.
  - Same cycle, same address, lock and write: the write lands and the busy bit ends set (lock wins; new reservation).
  - busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x), consistent with bypass.
- Locking an already-busy register is legal and leaves it busy. Writing a non-busy register is legal; its busy bit stays 0.
- Debug taps show committed contents, not bypassed data; they update one cycle after a write.
- No internal FSM beyond the read pipeline stage. The scoreboard is DEPTH independent set/clear flops.

Decomposition:
- Package reg_file_pkg holds:
  - the default RESET_VALS constant (CPU initial register image);
  - the AW derivation function;
  - named register index constants (REG_A=0, REG_R2=2).
- Sub-module reg_file_scoreboard holds the busy vector with set/clear/priority logic and the two busy lookups; parameters DEPTH and ZERO_REG.
- Storage, bypass and the read stage stay in the top module.

Test Plan:
- Reset with defaults, then rd_en with A=1, B=7 -> next cycle rd_data_a=1000, rd_data_b=5000, rd_valid=1; dbg_data0=10, dbg_data1=100.
- wr_en addr 3 data 0x00AB with rd_en A=3, B=3 in the same cycle -> next cycle both ports read 0x00AB; dbg unchanged; a later read of 3 also gives 0x00AB.
- lock_en addr 5, next cycle read A=5 -> busy_a=1, then rd_valid=0. Write 5 with 0x1234 while reading 5 -> busy_a=0, next cycle rd_data_a=0x1234, rd_valid=1.
- lock_en and wr_en both to addr 4 in one cycle, data 7 -> mem[4]=7 and busy[4]=1 (read 4 gives rd_valid=0).
- ZERO_REG=1: write 0x FFFF to addr 0, then lock 0, then read 0 -> rd_data=0, busy_a=0, rd_valid=1.
- Assert rst in the cycle after a read request and a write to addr 6 -> outputs zero, rd_valid=0, mem[6]=500, all busy bits clear.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and helpers for the parametrised register file
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Initial register image of the original CPU: entry i sits at bits [i*16 +: 16].
  localparam logic [DEFAULT_DEPTH*DEFAULT_WIDTH-1:0] CPU_RESET_IMAGE = {
    16'd5000, 16'd500, 16'd0, 16'd10000, 16'd1, 16'd100, 16'd1000, 16'd10
  };

  localparam int REG_A  = 0;
  localparam int REG_R2 = 2;

  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register busy bits: set on lock, cleared on writeback
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  parameter int AW       = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          lock_en,
  input  logic [AW-1:0] lock_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Lock is applied after the clear so a same-cycle lock and write leaves a fresh reservation.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (lock_en) busy_d[lock_addr] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a = busy_q[rd_addr_a] & ~(wr_en & (wr_addr == rd_addr_a));
  assign busy_b = busy_q[rd_addr_b] & ~(wr_en & (wr_addr == rd_addr_b));

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - 2R1W register file with 1-cycle registered reads, write bypass and busy scoreboard
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int                     WIDTH      = 16,
  parameter int                     DEPTH      = 8,
  parameter int                     AW         = addr_width(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0] RESET_VALS = CPU_RESET_IMAGE,
  parameter bit                     ZERO_REG   = 1'b0,
  parameter int                     DBG_ADDR0  = REG_A,
  parameter int                     DBG_ADDR1  = REG_R2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic [WIDTH-1:0] dbg_data0,
  output logic [WIDTH-1:0] dbg_data1
);

  localparam logic [AW-1:0] DBG0 = AW'(DBG_ADDR0);
  localparam logic [AW-1:0] DBG1 = AW'(DBG_ADDR1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
  logic [WIDTH-1:0] rd_data_a_d, rd_data_b_d;
  logic             rd_valid_q;
  logic             wr_hit;

  assign wr_hit = wr_en & ~(ZERO_REG & (wr_addr == '0));

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  // Write-first: a same-cycle write to the read address is forwarded, except to a hard-wired zero.
  always_comb begin
    rd_data_a_d = mem_q[rd_addr_a];
    if (wr_en && wr_addr == rd_addr_a) rd_data_a_d = wr_data;
    if (ZERO_REG && rd_addr_a == '0) rd_data_a_d = '0;

    rd_data_b_d = mem_q[rd_addr_b];
    if (wr_en && wr_addr == rd_addr_b) rd_data_b_d = wr_data;
    if (ZERO_REG && rd_addr_b == '0) rd_data_b_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VALS[i*WIDTH +: WIDTH];
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      if (wr_hit) mem_q[wr_addr] <= wr_data;
      if (rd_en) begin
        rd_data_a_q <= rd_data_a_d;
        rd_data_b_q <= rd_data_b_d;
      end
      rd_valid_q <= rd_en & ~(busy_a | busy_b);
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign dbg_data0 = mem_q[DBG0];
  assign dbg_data1 = mem_q[DBG1];

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - randomized check of reg_file_param (plain and zero-register builds) against a reference model
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0, lock_en = 1'b0;
  logic [2:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, lock_addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic [15:0] dbg0 [2];
  logic [15:0] dbg1 [2];
  logic        rdv [2];
  logic        bsa [2];
  logic        bsb [2];

  always #5 clk = ~clk;

  reg_file_param dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .rd_valid(rdv[0]), .busy_a(bsa[0]), .busy_b(bsb[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
    .dbg_data0(dbg0[0]), .dbg_data1(dbg1[0])
  );

  reg_file_param #(.ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .rd_valid(rdv[1]), .busy_a(bsa[1]), .busy_b(bsb[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
    .dbg_data0(dbg0[1]), .dbg_data1(dbg1[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: the CPU register image, index 0..7.
  int unsigned reset_img [8] = '{10, 1000, 100, 1, 10000, 0, 500, 5000};
  int unsigned m_mem [2][8];
  bit          m_busy [2][8];
  int unsigned e_rda [2];
  int unsigned e_rdb [2];
  bit          e_rdv [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = reset_img[i];
        m_busy[k][i] = 1'b0;
      end
      e_rda[k] = 0;
      e_rdb[k] = 0;
      e_rdv[k] = 1'b0;
    end
  endtask

  function automatic int unsigned model_read(input int k, input int a, input bit we, input int wa,
                                             input int unsigned wd);
    if (k == 1 && a == 0) return 0;
    if (we && wa == a) return wd;
    return m_mem[k][a];
  endfunction

  function automatic bit model_busy(input int k, input int a, input bit we, input int wa);
    return m_busy[k][a] && !(we && wa == a);
  endfunction

  task automatic check_regs(input string when);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s rd_data_a[%0d]", when, k), rda[k], e_rda[k]);
      chk($sformatf("%s rd_data_b[%0d]", when, k), rdb[k], e_rdb[k]);
      chk($sformatf("%s rd_valid[%0d]", when, k), rdv[k], e_rdv[k]);
      chk($sformatf("%s dbg_data1[%0d]", when, k), dbg1[k], m_mem[k][2]);
      if (k == 0) chk($sformatf("%s dbg_data0[0]", when), dbg0[k], m_mem[k][0]);
    end
  endtask

  task automatic step(input bit re, input int ra, input int rb, input bit we, input int wa,
                      input int unsigned wd, input bit le, input int la);
    bit ba, bb;
    @(negedge clk);
    rd_en = re; rd_addr_a = 3'(ra); rd_addr_b = 3'(rb);
    wr_en = we; wr_addr = 3'(wa); wr_data = 16'(wd);
    lock_en = le; lock_addr = 3'(la);
    #1;
    for (int k = 0; k < 2; k++) begin
      ba = model_busy(k, ra, we, wa);
      bb = model_busy(k, rb, we, wa);
      chk($sformatf("busy_a[%0d] addr %0d", k, ra), bsa[k], ba);
      chk($sformatf("busy_b[%0d] addr %0d", k, rb), bsb[k], bb);
      if (re) begin
        e_rda[k] = model_read(k, ra, we, wa, wd & 32'hFFFF);
        e_rdb[k] = model_read(k, rb, we, wa, wd & 32'hFFFF);
        e_rdv[k] = !(ba || bb);
      end else begin
        e_rdv[k] = 1'b0;
      end
      if (we && !(k == 1 && wa == 0)) m_mem[k][wa] = wd & 32'hFFFF;
      if (we) m_busy[k][wa] = 1'b0;
      if (le && !(k == 1 && la == 0)) m_busy[k][la] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_regs("post-edge");
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; lock_en = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Default image reads
    step(1, 1, 7, 0, 0, 0, 0, 0);
    // Same-cycle write bypass on both ports, then a plain re-read
    step(1, 3, 3, 1, 3, 16'h00AB, 0, 0);
    step(1, 3, 2, 0, 0, 0, 0, 0);
    // Lock, stalled read, then writeback releasing the lock
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(1, 5, 5, 0, 0, 0, 0, 0);
    step(1, 5, 1, 1, 5, 16'h1234, 0, 0);
    // Lock and write to the same register in one cycle
    step(0, 0, 0, 1, 4, 7, 1, 4);
    step(1, 4, 4, 0, 0, 0, 0, 0);
    // Register 0 write/lock/read
    step(0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset right after a read request and a write to 6, with locks outstanding
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(1, 6, 6, 1, 6, 16'h5555, 1, 6);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    check_regs("async-reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1, i, 7 - i, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom_range(0, 7),
           ($urandom_range(0, 9) < 4), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 7));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
